wb_alu_array: RTL and testbench
===============================

// Module: wb_alu_array
// PURPOSE
//   Wishbone-slave arithmetic engine for the user project area: NCH channels of WIDTH-bit operand pairs.
//   A START command sweeps all channels in sequence and computes A+B or A-B into per-channel result registers.
//   Completion is flagged in STATUS and on irq[0]; one selected channel result is driven onto io_out.
// PARAMETERS
//   WIDTH      8               operand width in bits (1..31)
//   NCH        4               number of channels (1..16)
//   BASE_ADDR  32'h3000_0000   Wishbone base; block decodes BASE_ADDR..BASE_ADDR+0x3FF
// PORTS
//   wb_clk_i   in   1          single clock
//   wb_rst_i   in   1          reset, asynchronous, active-low (0 = reset)
//   wbs_stb_i  in   1          Wishbone strobe
//   wbs_cyc_i  in   1          Wishbone cycle
//   wbs_we_i   in   1          1 = write
//   wbs_sel_i  in   4          byte lane enables
//   wbs_dat_i  in   32         write data
//   wbs_adr_i  in   32         byte address
//   wbs_ack_o  out  1          acknowledge, one-cycle pulse
//   wbs_dat_o  out  32         read data, valid while wbs_ack_o=1
//   io_out     out  WIDTH+1    {carry/borrow, result} of channel CTRL.OUT_SEL
//   io_oeb     out  WIDTH+1    all 0 (outputs enabled)
//   irq        out  3          irq[0] = DONE & IRQ_EN; irq[2:1] = 0
// BEHAVIOUR
//   Reset: wbs_ack_o=0, wbs_dat_o=0, all A/B/result regs=0, CTRL=0, STATUS=0, FSM=IDLE, io_out=0, irq=0.
//   Register map (offset from BASE_ADDR):
//     0x000 CTRL  [0] START (write-1, self-clearing, reads 0) [1] MODE 0=add 1=sub [2] IRQ_EN [11:8] OUT_SEL
//     0x004 STATUS[0] BUSY (RO) [1] DONE (W1C) [7:4] current channel index (RO)
//     0x100+8*i A_i, 0x104+8*i B_i (i<NCH), WIDTH bits RW, upper bits read 0
//     0x200+4*i RES_i (RO) = {carry/borrow at bit WIDTH, result[WIDTH-1:0]}
//   Bus: stb&cyc&!ack inside window -> ack exactly 1 cycle later; ack then low for >=1 cycle.
//     Unmapped offset inside window: ack, read 0, write ignored. Outside window: no ack.
//     Writes honour wbs_sel_i per byte; reads ignore sel.
//   FSM IDLE -> RUN on START write while IDLE; MODE latched into run_mode at START; idx=0, BUSY=1, DONE=0.
//     RUN: each cycle RES_idx <= op(A_idx,B_idx,run_mode); idx++; after idx==NCH-1 -> IDLE, BUSY=0, DONE=1.
//     Latency: START ack cycle + NCH cycles to DONE.
//   Arithmetic: add -> {cout,sum}=A+B (WIDTH+1 bits); sub -> result=(A-B) mod 2^WIDTH, bit WIDTH = (A<B).
//   Boundaries:
//     START while BUSY: acked, ignored (no restart, run_mode unchanged).
//     A/B write while BUSY: acked, dropped; CTRL MODE/IRQ_EN/OUT_SEL writes while BUSY take effect.
//     DONE W1C in the same cycle FSM sets DONE: set wins.
//     OUT_SEL >= NCH: io_out=0.
//     Reset low mid-run: all state cleared immediately (async); no partial DONE.
//     RES reads during RUN return current contents (old or new per channel).
// STRUCTURE
//   Package wb_alu_pkg: register offsets, CTRL/STATUS bit positions, FSM state enum {IDLE,RUN}, MODE codes.
//   One sub-module alu_lane: combinational WIDTH-bit add/sub with carry/borrow out, shared across channels
//   via idx mux; top holds bus decode, register file, FSM.
// TESTING (WIDTH=8, NCH=4)
//   Reset low mid-RUN -> BUSY=0, RES_*=0, irq=0, wbs_ack_o=0 immediately.
//   A0=0xFF,B0=0x01,A3=0x12,B3=0x34, CTRL=0x1 (add) -> after 4 cycles DONE=1; RES0=0x100, RES3=0x046.
//   MODE=1, A1=0x05,B1=0x07, START -> RES1=0x1FE (borrow=1); A2=0x07,B2=0x05 -> RES2=0x002.
//   IRQ_EN=1, START -> irq[0] rises with DONE; write STATUS=0x2 -> DONE=0, irq[0]=0.
//   START, then during BUSY write A0=0xAA and START again -> A0 unchanged, single DONE after 4 cycles.
//   Read 0x0F0 (in window) -> ack, data 0; access BASE_ADDR+0x400 -> no ack; OUT_SEL=3 -> io_out=RES3.

Source files
------------

// File: rtl/wb_alu_array_pkg.sv
// Shared constants for the Wishbone add/sub channel engine: register map,
// CTRL/STATUS bit positions, FSM states and arithmetic mode codes.
package wb_alu_pkg;

  localparam logic [9:0] OFF_CTRL   = 10'h000;
  localparam logic [9:0] OFF_STATUS = 10'h004;
  localparam logic [1:0] REGION_AB  = 2'b01;   // 0x100..0x1FF operand pairs
  localparam logic [1:0] REGION_RES = 2'b10;   // 0x200..0x2FF results

  localparam int CTRL_START  = 0;
  localparam int CTRL_MODE   = 1;
  localparam int CTRL_IRQ_EN = 2;
  localparam int CTRL_SEL_LO = 8;

  localparam int ST_DONE = 1;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  typedef enum logic {
    MODE_ADD = 1'b0,
    MODE_SUB = 1'b1
  } mode_t;

endpackage

// File: rtl/wb_alu_array_if.sv
// Wishbone slave bus bundle; signal names keep the classic _i/_o suffixes
// so they line up with the user-project wrapper.
interface wb_alu_array_if;
  logic        wbs_stb_i;
  logic        wbs_cyc_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_dat_i;
  logic [31:0] wbs_adr_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport master (
    output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
    input  wbs_ack_o, wbs_dat_o
  );

  modport slave (
    input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
    output wbs_ack_o, wbs_dat_o
  );
endinterface

// File: rtl/wb_alu_array_alu_lane.sv
// Combinational WIDTH-bit add/sub; the extra top bit is carry for add and
// borrow (a < b) for sub, which falls out of a WIDTH+1 bit subtraction.
module alu_lane
  import wb_alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  mode_t            mode,
  output logic [WIDTH:0]   y
);

  always_comb begin
    if (mode == MODE_SUB) y = {1'b0, a} - {1'b0, b};
    else                  y = {1'b0, a} + {1'b0, b};
  end

endmodule

// File: rtl/wb_alu_array.sv
// Wishbone slave holding NCH operand pairs; START sweeps one channel per cycle
// through a single shared alu_lane and raises DONE / irq[0] at the end.
module wb_alu_array
  import wb_alu_pkg::*;
#(
  parameter int          WIDTH     = 8,
  parameter int          NCH       = 4,
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  wb_alu_array_if.slave    wbs,
  output logic [WIDTH:0]   io_out,
  output logic [WIDTH:0]   io_oeb,
  output logic [2:0]       irq
);

  localparam int IW = 4;

  state_t            state_q, state_d;
  logic [IW-1:0]     idx_q;
  mode_t             run_mode;
  mode_t             mode;
  logic              irq_en;
  logic [IW-1:0]     out_sel;
  logic              done_q;
  logic              busy;
  logic              last;

  logic [WIDTH-1:0]  a_q   [NCH];
  logic [WIDTH-1:0]  b_q   [NCH];
  logic [WIDTH:0]    res_q [NCH];

  logic              ack_q;
  logic [31:0]       dat_q;
  logic              in_win, req, wr;
  logic [9:0]        off;
  logic              ab_hit, res_hit, is_b;
  logic [4:0]        ab_ch;
  logic [5:0]        res_ch;
  logic              start_req, done_clr;
  logic [31:0]       rdata;
  logic [WIDTH-1:0]  cur_a, cur_b;
  logic [WIDTH:0]    lane_y;
  logic              unused;

  assign unused = ^wbs.wbs_dat_i;

  // ---------------- bus decode ----------------
  assign in_win  = (wbs.wbs_adr_i[31:10] == BASE_ADDR[31:10]);
  assign off     = wbs.wbs_adr_i[9:0];
  assign req     = wbs.wbs_stb_i && wbs.wbs_cyc_i && !ack_q && in_win;
  assign wr      = req && wbs.wbs_we_i;
  assign ab_hit  = (off[9:8] == REGION_AB)  && (off[1:0] == 2'b00);
  assign res_hit = (off[9:8] == REGION_RES) && (off[1:0] == 2'b00);
  assign ab_ch   = off[7:3];
  assign is_b    = off[2];
  assign res_ch  = off[7:2];

  assign busy      = (state_q == RUN);
  assign last      = (idx_q == IW'(NCH - 1));
  assign start_req = wr && (off == OFF_CTRL) && wbs.wbs_sel_i[0] &&
                     wbs.wbs_dat_i[CTRL_START] && (state_q == IDLE);
  assign done_clr  = wr && (off == OFF_STATUS) && wbs.wbs_sel_i[0] &&
                     wbs.wbs_dat_i[ST_DONE];

  always_comb begin
    rdata = '0;
    if (off == OFF_CTRL) begin
      rdata = 32'({out_sel, 5'b0, irq_en, mode, 1'b0});
    end else if (off == OFF_STATUS) begin
      rdata = 32'({idx_q, 2'b0, done_q, busy});
    end else if (ab_hit) begin
      for (int i = 0; i < NCH; i++)
        if (ab_ch == 5'(i)) rdata = is_b ? 32'(b_q[i]) : 32'(a_q[i]);
    end else if (res_hit) begin
      for (int i = 0; i < NCH; i++)
        if (res_ch == 6'(i)) rdata = 32'(res_q[i]);
    end
  end

  // Ack is registered from the request, so it can never be high two cycles running.
  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      ack_q <= 1'b0;
      dat_q <= '0;
    end else begin
      ack_q <= req;
      dat_q <= (req && !wbs.wbs_we_i) ? rdata : '0;
    end
  end

  assign wbs.wbs_ack_o = ack_q;
  assign wbs.wbs_dat_o = dat_q;

  // ---------------- CTRL / STATUS ----------------
  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      mode     <= MODE_ADD;
      irq_en   <= 1'b0;
      out_sel  <= '0;
      run_mode <= MODE_ADD;
      done_q   <= 1'b0;
    end else begin
      if (wr && (off == OFF_CTRL)) begin
        if (wbs.wbs_sel_i[0]) begin
          mode   <= mode_t'(wbs.wbs_dat_i[CTRL_MODE]);
          irq_en <= wbs.wbs_dat_i[CTRL_IRQ_EN];
        end
        if (wbs.wbs_sel_i[1]) out_sel <= wbs.wbs_dat_i[CTRL_SEL_LO +: IW];
      end
      if (start_req) run_mode <= mode_t'(wbs.wbs_dat_i[CTRL_MODE]);
      // The FSM setting DONE beats a W1C landing on the same edge.
      if (busy && last)   done_q <= 1'b1;
      else if (done_clr)  done_q <= 1'b0;
      else if (start_req) done_q <= 1'b0;
    end
  end

  // ---------------- FSM ----------------
  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) state_q <= IDLE;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_req) state_d = RUN;
      RUN:     if (last)      state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i)      idx_q <= '0;
    else if (start_req) idx_q <= '0;
    else if (busy)      idx_q <= last ? '0 : idx_q + IW'(1);
  end

  // ---------------- datapath ----------------
  always_comb begin
    cur_a = '0;
    cur_b = '0;
    for (int i = 0; i < NCH; i++)
      if (idx_q == IW'(i)) begin
        cur_a = a_q[i];
        cur_b = b_q[i];
      end
  end

  alu_lane #(.WIDTH(WIDTH)) u_lane (
    .a    (cur_a),
    .b    (cur_b),
    .mode (run_mode),
    .y    (lane_y)
  );

  // Operand writes are dropped while a sweep is in flight so results stay coherent.
  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      for (int i = 0; i < NCH; i++) begin
        a_q[i]   <= '0;
        b_q[i]   <= '0;
        res_q[i] <= '0;
      end
    end else begin
      if (wr && ab_hit && !busy) begin
        for (int i = 0; i < NCH; i++)
          if (ab_ch == 5'(i))
            for (int j = 0; j < WIDTH; j++)
              if (wbs.wbs_sel_i[j/8]) begin
                if (is_b) b_q[i][j] <= wbs.wbs_dat_i[j];
                else      a_q[i][j] <= wbs.wbs_dat_i[j];
              end
      end
      if (busy) begin
        for (int i = 0; i < NCH; i++)
          if (idx_q == IW'(i)) res_q[i] <= lane_y;
      end
    end
  end

  // ---------------- outputs ----------------
  always_comb begin
    io_out = '0;
    for (int i = 0; i < NCH; i++)
      if (out_sel == IW'(i)) io_out = res_q[i];
  end

  assign io_oeb = '0;
  assign irq    = {2'b00, done_q & irq_en};

endmodule

// File: tb/tb_wb_alu_array.sv
// Bench for wb_alu_array: bus accesses push expectations into a queue and a
// negedge monitor pops and compares whenever the slave acknowledges.
module tb_wb_alu_array;
  localparam int          WIDTH = 8;
  localparam int          NCH   = 4;
  localparam logic [31:0] BASE  = 32'h3000_0000;

  logic             clk;
  logic             rst_n;
  logic [WIDTH:0]   io_out;
  logic [WIDTH:0]   io_oeb;
  logic [2:0]       irq;

  int tests = 0;
  int fails = 0;

  logic [31:0] exp_q [$];
  logic [31:0] adr_q [$];
  bit          rd_q  [$];

  wb_alu_array_if bus ();

  wb_alu_array #(.WIDTH(WIDTH), .NCH(NCH), .BASE_ADDR(BASE)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst_n),
    .wbs      (bus),
    .io_out   (io_out),
    .io_oeb   (io_oeb),
    .irq      (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard monitor
  logic [31:0] m_exp, m_adr;
  bit          m_rd;
  always @(negedge clk) begin
    if (bus.wbs_ack_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_ack: got ack with no pending access");
      end else begin
        m_exp = exp_q.pop_front();
        m_adr = adr_q.pop_front();
        m_rd  = rd_q.pop_front();
        if (m_rd) begin
          tests++;
          if (bus.wbs_dat_o !== m_exp) begin
            fails++;
            $display("FAIL rd@%h: got %h expected %h", m_adr, bus.wbs_dat_o, m_exp);
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic access(input logic [31:0] adr, input bit we, input logic [31:0] dat,
                        input logic [3:0] sel, input bit expect_ack, input logic [31:0] exp);
    bit got;
    got = 1'b0;
    if (expect_ack) begin
      exp_q.push_back(exp);
      adr_q.push_back(adr);
      rd_q.push_back(!we);
    end
    @(posedge clk); #1;
    bus.wbs_stb_i = 1'b1; bus.wbs_cyc_i = 1'b1; bus.wbs_we_i = we;
    bus.wbs_sel_i = sel;  bus.wbs_dat_i = dat;  bus.wbs_adr_i = adr;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      if (bus.wbs_ack_o) begin got = 1'b1; break; end
    end
    bus.wbs_stb_i = 1'b0; bus.wbs_cyc_i = 1'b0; bus.wbs_we_i = 1'b0;
    if (expect_ack && !got) begin
      tests++; fails++;
      $display("FAIL ack_timeout@%h: got no ack expected ack", adr);
      void'(exp_q.pop_back()); void'(adr_q.pop_back()); void'(rd_q.pop_back());
    end
    if (!expect_ack) chk("no_ack", 32'(got), 32'd0);
  endtask

  task automatic wr(input logic [9:0] off, input logic [31:0] dat);
    access(BASE + 32'(off), 1'b1, dat, 4'hF, 1'b1, 32'h0);
  endtask

  task automatic rd(input logic [9:0] off, input logic [31:0] exp);
    access(BASE + 32'(off), 1'b0, 32'h0, 4'hF, 1'b1, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    bus.wbs_stb_i = 1'b0; bus.wbs_cyc_i = 1'b0; bus.wbs_we_i = 1'b0;
    bus.wbs_sel_i = 4'h0; bus.wbs_dat_i = 32'h0; bus.wbs_adr_i = 32'h0;
    #2;
    chk("rst_ack", 32'(bus.wbs_ack_o), 0);
    chk("rst_io_out", 32'(io_out), 0);
    chk("rst_irq", 32'(irq), 0);
    chk("io_oeb", 32'(io_oeb), 0);
    wait_cycles(3);
    rst_n = 1'b1;
    rd(10'h000, 32'h0);
    rd(10'h004, 32'h0);
    rd(10'h200, 32'h0);

    // Add sweep
    wr(10'h100, 32'hFF); wr(10'h104, 32'h01);
    wr(10'h118, 32'h12); wr(10'h11C, 32'h34);
    wr(10'h000, 32'h1);
    wait_cycles(4);
    rd(10'h004, 32'h2);
    rd(10'h200, 32'h100);
    rd(10'h20C, 32'h046);
    rd(10'h204, 32'h000);
    rd(10'h100, 32'hFF);

    // Sub sweep
    wr(10'h108, 32'h05); wr(10'h10C, 32'h07);
    wr(10'h110, 32'h07); wr(10'h114, 32'h05);
    wr(10'h000, 32'h3);
    wait_cycles(4);
    rd(10'h204, 32'h1FE);
    rd(10'h208, 32'h002);
    rd(10'h200, 32'h0FE);
    rd(10'h20C, 32'h1DE);

    // IRQ timing and DONE W1C
    wr(10'h000, 32'h7);
    chk("irq_after_start", 32'(irq), 0);
    wait_cycles(3);
    chk("irq_cycle3", 32'(irq), 0);
    wait_cycles(1);
    chk("irq_cycle4", 32'(irq), 1);
    wr(10'h004, 32'h2);
    chk("irq_after_w1c", 32'(irq), 0);
    rd(10'h004, 32'h0);

    // Operand write and restart while busy are both ignored
    wr(10'h000, 32'h1);
    wr(10'h100, 32'hAA);
    wr(10'h000, 32'h3);
    wait_cycles(6);
    rd(10'h004, 32'h2);
    rd(10'h100, 32'hFF);
    rd(10'h200, 32'h100);
    rd(10'h000, 32'h2);

    // Window edges
    rd(10'h0F0, 32'h0);
    wr(10'h0F0, 32'hFFFF_FFFF);
    rd(10'h0F0, 32'h0);
    access(BASE + 32'h400, 1'b0, 32'h0, 4'hF, 1'b0, 32'h0);
    access(BASE - 32'h4,   1'b1, 32'h1, 4'hF, 1'b0, 32'h0);

    // Output channel select
    wr(10'h000, 32'h300);
    chk("io_out_sel3", 32'(io_out), 32'h046);
    wr(10'h000, 32'h500);
    chk("io_out_sel5", 32'(io_out), 32'h0);
    wr(10'h000, 32'h100);
    chk("io_out_sel1", 32'(io_out), 32'h00C);

    // Byte lanes
    access(BASE + 32'h108, 1'b1, 32'hFFFF_FF99, 4'b0010, 1'b1, 32'h0);
    rd(10'h108, 32'h05);
    wr(10'h110, 32'h1234);
    rd(10'h110, 32'h34);

    // Reset in the middle of a sweep
    wr(10'h000, 32'h005);
    chk("io_out_pre_rst", 32'(io_out), 32'h100);
    wait_cycles(2);
    rst_n = 1'b0;
    #1;
    chk("midrst_ack", 32'(bus.wbs_ack_o), 0);
    chk("midrst_irq", 32'(irq), 0);
    chk("midrst_io_out", 32'(io_out), 0);
    #2;
    rst_n = 1'b1;
    rd(10'h004, 32'h0);
    rd(10'h200, 32'h0);
    rd(10'h118, 32'h0);
    rd(10'h000, 32'h0);

    wait_cycles(3);
    chk("queue_drained", 32'(exp_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
